seq_left_shifter: RTL and testbench

Multi-cycle parameterized left shifter/rotator. It is the opposite-direction, sequential counterpart of the team's combinational right shifter. It accepts an operand and a shift amount on a start pulse and shifts one bit position per clock. It reports completion with a one-cycle done strobe. It is used in lab datapaths where a full barrel left shifter is not wanted, and shares operand naming with the right shifter so the two drop into the same top level.

---
 rtl/seq_left_shifter_pkg.sv | 14 +
 rtl/seq_left_shifter_shift_counter.sv | 42 ++++
 rtl/seq_left_shifter.sv | 108 ++++++++++
 tb/tb_seq_left_shifter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_left_shifter_pkg.sv
// seq_shift_pkg: shared types and constants for the sequential left shifter.
//   state_t     - controller state encoding (IDLE, SHIFT, DONE)
//   DefaultN    - default shift-amount width; data width is 2**N
package seq_shift_pkg;

   localparam int unsigned DefaultN = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_left_shifter_shift_counter.sv
// shift_counter: loadable N-bit down counter that tracks remaining shift steps.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset, clears the count
//   load     in   load load_val into the count (has priority over dec)
//   dec      in   decrement the count by one (saturates at zero)
//   load_val in   N-bit value to load
//   last     out  high while count == 1, i.e. the current step is the final one
module shift_counter #(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [N-1:0] load_val,
   output logic         last
);

   logic [N-1:0] count_q;
   logic [N-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - N'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == N'(1));

endmodule

// File: rtl/seq_left_shifter.sv
// seq_left_shifter: multi-cycle left shifter / rotator, one bit position per clock.
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   request; only sampled in IDLE
//   num     in   W-bit operand, captured on accepted start
//   shift   in   N-bit left shift amount, captured on accepted start
//   rotate  in   0 = logical (zero fill), 1 = rotate left; captured on accepted start
//   result  out  working/final value; valid with done, held until the next accepted start
//   busy    out  high while shifting
//   done    out  one-cycle completion strobe
module seq_left_shifter
   import seq_shift_pkg::*;
#(
   parameter int unsigned N = DefaultN,
   parameter int unsigned W = 2 ** N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] num,
   input  logic [N-1:0] shift,
   input  logic         rotate,
   output logic [W-1:0] result,
   output logic         busy,
   output logic         done
);

   state_t       state_q;
   logic [W-1:0] result_q;
   logic [W-1:0] shifted_d;
   logic         mode_q;
   logic         busy_q;
   logic         done_q;
   logic         accept;
   logic         cnt_load;
   logic         cnt_dec;
   logic         cnt_last;

   assign accept   = (state_q == IDLE) && start;
   assign cnt_load = accept;
   assign cnt_dec  = (state_q == SHIFT);

   // One-position step; the bit shifted out of the MSB either wraps or is dropped.
   always_comb begin
      shifted_d = {result_q[W-2:0], (mode_q ? result_q[W-1] : 1'b0)};
   end

   shift_counter #(
      .N (N)
   ) u_shift_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (shift),
      .last     (cnt_last)
   );

   // Outputs are registered alongside the state so busy/done never depend on inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= '0;
         mode_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  result_q <= num;
                  mode_q   <= rotate;
                  if (shift != '0) begin
                     state_q <= SHIFT;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               result_q <= shifted_d;
               if (cnt_last) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_seq_left_shifter.sv
module tb_seq_left_shifter;

   localparam int unsigned N = 3;
   localparam int unsigned W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] num;
   logic [N-1:0] shift;
   logic         rotate;
   logic [W-1:0] result;
   logic         busy;
   logic         done;

   int compared;
   int mismatched;

   seq_left_shifter #(
      .N (N)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .num    (num),
      .shift  (shift),
      .rotate (rotate),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation and check busy/done timing and the final result.
   task automatic run_op(input string tag, input logic [W-1:0] n, input logic [N-1:0] s,
                         input logic r, input logic [W-1:0] exp_res);
      num    = n;
      shift  = s;
      rotate = r;
      start  = 1'b1;
      step();
      start = 1'b0;
      num   = 8'hA5;
      shift = 3'd1;
      for (int i = 1; i <= int'(s); i++) begin
         check({tag, " busy"}, 32'(busy), 32'd1);
         check({tag, " no-done-while-busy"}, 32'(done), 32'd0);
         step();
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy-at-done"}, 32'(busy), 32'd0);
      check({tag, " result"}, 32'(result), 32'(exp_res));
      step();
      check({tag, " done-drops"}, 32'(done), 32'd0);
      check({tag, " result-holds"}, 32'(result), 32'(exp_res));
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset  = 1'b1;
      start  = 1'b0;
      num    = '0;
      shift  = '0;
      rotate = 1'b0;
      step();
      step();
      check("reset result", 32'(result), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      reset = 1'b0;
      step();

      run_op("lsl3", 8'b1101_0010, 3'd3, 1'b0, 8'b1001_0000);
      run_op("rol3", 8'b1101_0010, 3'd3, 1'b1, 8'b1001_0110);
      run_op("lsl0", 8'b1101_0010, 3'd0, 1'b0, 8'b1101_0010);
      run_op("lsl7", 8'b1101_0010, 3'd7, 1'b0, 8'b0000_0000);
      run_op("rol7", 8'b1101_0010, 3'd7, 1'b1, 8'b0110_1001);
      run_op("rol1", 8'b1000_0001, 3'd1, 1'b1, 8'b0000_0011);

      // Start held through SHIFT and DONE with a different operand: ignored there,
      // then accepted in the following IDLE cycle.
      num    = 8'b1101_0010;
      shift  = 3'd3;
      rotate = 1'b0;
      start  = 1'b1;
      step();
      num   = 8'hFF;
      shift = 3'd0;
      for (int i = 1; i <= 3; i++) begin
         check("ign busy", 32'(busy), 32'd1);
         step();
      end
      check("ign done", 32'(done), 32'd1);
      check("ign result", 32'(result), 32'h90);
      step();
      check("ign idle busy", 32'(busy), 32'd0);
      check("ign idle done", 32'(done), 32'd0);
      check("ign idle result", 32'(result), 32'h90);
      step();
      start = 1'b0;
      check("re-accept done", 32'(done), 32'd1);
      check("re-accept result", 32'(result), 32'hFF);
      step();

      // Reset in cycle t+2 of a shift=5 rotate operation.
      num    = 8'b1101_0010;
      shift  = 3'd5;
      rotate = 1'b1;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("rst-mid busy t+1", 32'(busy), 32'd1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst-mid result", 32'(result), 32'd0);
      check("rst-mid busy", 32'(busy), 32'd0);
      check("rst-mid done", 32'(done), 32'd0);
      begin
         int strobes;
         strobes = 0;
         for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) strobes++;
         end
         check("rst-mid no strobe", 32'(strobes), 32'd0);
      end

      // Rotate mode must have been cleared by reset: a fresh logical op zero-fills.
      run_op("post-rst lsl2", 8'b1100_0001, 3'd2, 1'b0, 8'b0000_0100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
